alu_bcd: RTL and testbench
==========================

# alu_bcd

Parametrised, sequenced ALU that supersedes the single-cycle add/logic/shift unit in the CPU datapath. It takes a WIDTH-bit A/B operand pair, an op select, a carry-in and a decimal-mode flag. Binary ops return in one cycle. Decimal add/subtract is corrected one BCD nibble per cycle under a small state machine. It produces full flag outputs (carry, overflow, half-carry, zero, negative) for the status register and uses a ready/valid handshake toward the decode/sequencer.

## Interface
- WIDTH, 8, operand/result width; must be a multiple of 4 and ≥ 4; N = WIDTH/4 nibbles
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, synchronous, active-high; all inputs ignored while high
- i_valid  in  1  op request; accepted on a rising edge when i_valid & o_ready & !i_rst
- o_ready  out  1  high in IDLE (combinational from state)
- i_op  in  3  0 SUM, 1 SUB, 2 AND, 3 OR, 4 EOR, 5 SR, 6 SL, 7 PASS
- i_ai, i_bi  in  WIDTH  operands
- i_carry  in  1  carry-in (SUM/SUB), shift-in bit (SR/SL)
- i_dec  in  1  decimal mode; honoured only for SUM/SUB
- o_add  out  WIDTH  result register, held until the next completion
- o_acr, o_avr, o_hc, o_zero, o_neg  out  1 each  carry, signed overflow, half-carry, result==0, result MSB; held with o_add
- o_valid  out  1  one-cycle pulse when o_add and flags update

## Operation
- States: IDLE, DEC. Reset → IDLE. Reset values: all outputs 0 except o_ready = 1.
- **Binary path.** Applies to any accepted op with !(i_dec & op∈{SUM,SUB}). Result and flags are registered at the accept edge; state stays IDLE.
  - SUM: {acr, add} = ai + bi + c.
  - SUB: {acr, add} = ai + ~bi + c, so acr = not-borrow.
  - avr = signed overflow (SUM/SUB only). hc = carry out of bit 3 (SUM/SUB only).
  - AND/OR/EOR: bitwise; acr = avr = hc = 0.
  - SR: add = {c, ai[W-1:1]}, acr = ai[0].
  - SL: add = {ai[W-2:0], c}, acr = ai[W-1].
  - PASS: add = ai, acr = 0.
  - Shifts and PASS: avr = hc = 0.
- **Decimal path.** Applies to an accepted SUM/SUB with i_dec.
  - The accept edge latches ai, bi, op, c. It also latches avr = binary signed overflow of the same operands. The nibble counter is set to 0 and the state moves to DEC.
  - Each DEC edge processes nibble k = counter, LSB first, with a running carry initialised to c.
  - SUM nibble: s = a_k + b_k + cy. If s > 9, then s = s + 6 (mod 16) and cy = 1; otherwise cy = 0.
  - SUB nibble: d = a_k − b_k − !cy. If d < 0, then d = d + 10 and cy = 0; otherwise cy = 1.
  - hc = cy after nibble 0.
  - After nibble N−1: o_add = assembled result, acr = final cy, zero/neg from the decimal result, o_valid pulses, state returns to IDLE.
  - Non-BCD operand nibbles (>9) are processed by the same rule with no error flag; the result is defined by the rule only.
- i_valid while busy (DEC) is ignored and the request is not queued. The requester must hold it until o_ready.
- If i_rst asserts mid-DEC, the unit goes to IDLE, the partial result is discarded, no o_valid is issued, and outputs return to reset values.

## Timing
- Binary: accept at edge E0; o_valid and result in the cycle after E0. Latency 1. o_ready stays high, so back-to-back ops give 1 result per cycle.
- Decimal: accept at E0; nibbles at E1..EN; o_valid in the cycle after EN. Latency N+1 (3 for WIDTH=8). o_ready is low from after E0 through EN.
- A new op can be accepted in the same cycle that a decimal o_valid is high.
- Outputs are registered only; no combinational input→output path except i_* → nothing (o_ready depends only on state).

## Configuration
- ALU_BCD_EN defined: decimal path and DEC state are present as described.
- ALU_BCD_EN undefined: i_dec is ignored and all ops use the binary path. The DEC state and nibble counter are removed and o_ready is constant 1. Interface is unchanged.

## Test plan
- WIDTH=8 SUM, ai=0x50, bi=0x50, c=0, dec=0 → next cycle add=0xA0, avr=1, acr=0, neg=1, zero=0, hc=0, o_valid pulse.
- SUB, ai=0x00, bi=0x01, c=1, dec=0 → add=0xFF, acr=0, avr=0, neg=1; then back-to-back AND 0xF0&0x3C → 0x30 on the next cycle.
- Decimal SUM, ai=0x58, bi=0x46, c=1 → o_ready low 2 cycles, o_valid on the 3rd cycle, add=0x05, acr=1, hc=1, zero=0.
- Decimal SUB, ai=0x12, bi=0x21, c=1 → add=0x91, acr=0, neg=1; i_valid pulsed during DEC is ignored (no extra o_valid).
- ai=0x81: SR c=1 → add=0xC0, acr=1; SL c=0 → add=0x02, acr=1; PASS → add=0x81, acr=0.
- Start a decimal op and assert i_rst one cycle later → no o_valid, o_add=0, all flags 0, o_ready=1. An op issued the cycle after deassert is accepted.

Source files
------------

// File: rtl/alu_bcd.sv
// Sequenced ALU: single-cycle binary ops plus nibble-serial BCD add/subtract.
// Define ALU_BCD_EN to build the decimal path (DEC state, nibble counter).
module alu_bcd #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_ai,
  input  logic [WIDTH-1:0] i_bi,
  input  logic             i_carry,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_add,
  output logic             o_acr,
  output logic             o_avr,
  output logic             o_hc,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_valid
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_SUM  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_EOR  = 3'd4;
  localparam logic [2:0] OP_SR   = 3'd5;
  localparam logic [2:0] OP_SL   = 3'd6;

  logic [WIDTH-1:0] b_eff, bin_res;
  logic [WIDTH:0]   sum_ext;
  logic [4:0]       low_sum;
  logic             arith_avr, bin_acr, bin_avr, bin_hc;
  logic             is_arith, accept, bin_accept, dec_accept;

  assign is_arith = (i_op == OP_SUM) || (i_op == OP_SUB);
  assign accept   = i_valid & o_ready;

  // SUB is computed as ai + ~bi + c so that carry-out means "no borrow".
  always_comb begin
    b_eff     = (i_op == OP_SUB) ? ~i_bi : i_bi;
    sum_ext   = {1'b0, i_ai} + {1'b0, b_eff} + {{WIDTH{1'b0}}, i_carry};
    low_sum   = {1'b0, i_ai[3:0]} + {1'b0, b_eff[3:0]} + {4'b0, i_carry};
    arith_avr = (i_ai[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != i_ai[WIDTH-1]);
    bin_res   = i_ai;
    bin_acr   = 1'b0;
    bin_avr   = 1'b0;
    bin_hc    = 1'b0;
    case (i_op)
      OP_SUM, OP_SUB: begin
        bin_res = sum_ext[WIDTH-1:0];
        bin_acr = sum_ext[WIDTH];
        bin_avr = arith_avr;
        bin_hc  = low_sum[4];
      end
      OP_AND: bin_res = i_ai & i_bi;
      OP_OR:  bin_res = i_ai | i_bi;
      OP_EOR: bin_res = i_ai ^ i_bi;
      OP_SR: begin
        bin_res = {i_carry, i_ai[WIDTH-1:1]};
        bin_acr = i_ai[0];
      end
      OP_SL: begin
        bin_res = {i_ai[WIDTH-2:0], i_carry};
        bin_acr = i_ai[WIDTH-1];
      end
      default: bin_res = i_ai;
    endcase
  end

`ifdef ALU_BCD_EN
  typedef enum logic {IDLE, DEC} state_t;
  state_t state, state_next;

  logic [CW-1:0]    nib_cnt;
  logic [WIDTH-1:0] dec_a, dec_b, dec_res, res_next;
  logic             dec_sub, dec_cy, dec_hc, dec_avr;
  logic [3:0]       a_k, b_k, nib_val;
  logic [4:0]       s5;
  logic [5:0]       d6;
  logic             cy_next, last_nib;

  assign o_ready    = (state == IDLE);
  assign dec_accept = accept & i_dec & is_arith;
  assign bin_accept = accept & ~(i_dec & is_arith);
  assign last_nib   = (nib_cnt == CW'(N - 1));

  // One BCD digit per cycle; the result register fills from the LSB upward.
  always_comb begin
    a_k      = 4'(dec_a >> (4 * nib_cnt));
    b_k      = 4'(dec_b >> (4 * nib_cnt));
    s5       = {1'b0, a_k} + {1'b0, b_k} + {4'b0, dec_cy};
    d6       = {2'b0, a_k} - {2'b0, b_k} - {5'b0, ~dec_cy};
    nib_val  = s5[3:0];
    cy_next  = 1'b0;
    if (dec_sub) begin
      if (d6[5]) begin
        nib_val = 4'(d6 + 6'd10);
        cy_next = 1'b0;
      end else begin
        nib_val = d6[3:0];
        cy_next = 1'b1;
      end
    end else if (s5 > 5'd9) begin
      nib_val = 4'(s5 + 5'd6);
      cy_next = 1'b1;
    end
    res_next = dec_res | (WIDTH'(nib_val) << (4 * nib_cnt));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dec_accept) state_next = DEC;
      DEC:     if (last_nib)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end
`else
  logic unused_dec;
  assign unused_dec = i_dec;
  assign o_ready    = 1'b1;
  assign dec_accept = 1'b0;
  assign bin_accept = accept;
`endif

  // Outputs hold the last completed result; o_valid pulses on each completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_add   <= '0;
      o_acr   <= 1'b0;
      o_avr   <= 1'b0;
      o_hc    <= 1'b0;
      o_zero  <= 1'b0;
      o_neg   <= 1'b0;
      o_valid <= 1'b0;
`ifdef ALU_BCD_EN
      nib_cnt <= '0;
      dec_a   <= '0;
      dec_b   <= '0;
      dec_res <= '0;
      dec_sub <= 1'b0;
      dec_cy  <= 1'b0;
      dec_hc  <= 1'b0;
      dec_avr <= 1'b0;
`endif
    end else begin
      o_valid <= 1'b0;
      if (bin_accept) begin
        o_add   <= bin_res;
        o_acr   <= bin_acr;
        o_avr   <= bin_avr;
        o_hc    <= bin_hc;
        o_zero  <= (bin_res == '0);
        o_neg   <= bin_res[WIDTH-1];
        o_valid <= 1'b1;
      end
`ifdef ALU_BCD_EN
      if (dec_accept) begin
        dec_a   <= i_ai;
        dec_b   <= i_bi;
        dec_sub <= (i_op == OP_SUB);
        dec_cy  <= i_carry;
        dec_avr <= arith_avr;
        dec_res <= '0;
        nib_cnt <= '0;
      end else if (state == DEC) begin
        dec_cy  <= cy_next;
        dec_res <= res_next;
        nib_cnt <= nib_cnt + CW'(1);
        if (nib_cnt == '0) dec_hc <= cy_next;
        if (last_nib) begin
          o_add   <= res_next;
          o_acr   <= cy_next;
          o_avr   <= dec_avr;
          o_hc    <= (nib_cnt == '0) ? cy_next : dec_hc;
          o_zero  <= (res_next == '0);
          o_neg   <= res_next[WIDTH-1];
          o_valid <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_bcd.sv
// Scoreboard bench for alu_bcd: decimal-integer reference model, random plus directed ops.
module tb_alu_bcd;
  localparam int W = 8;

`ifdef ALU_BCD_EN
  localparam bit BCD_EN = 1'b1;
`else
  localparam bit BCD_EN = 1'b0;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst, i_valid, i_carry, i_dec;
  logic         o_ready, o_acr, o_avr, o_hc, o_zero, o_neg, o_valid;
  logic [2:0]   i_op;
  logic [W-1:0] i_ai, i_bi, o_add;

  typedef struct packed {
    logic [7:0] add;
    logic       acr;
    logic       avr;
    logic       hc;
    logic       zero;
    logic       neg;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  alu_bcd #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_ai(i_ai), .i_bi(i_bi), .i_carry(i_carry), .i_dec(i_dec),
    .o_add(o_add), .o_acr(o_acr), .o_avr(o_avr), .o_hc(o_hc),
    .o_zero(o_zero), .o_neg(o_neg), .o_valid(o_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: binary ops via integer arithmetic, decimal ops via base-10 integers.
  function automatic exp_t model(input int op, input int a, input int b, input int c, input int dec);
    exp_t e;
    int r, sa, sb, sr, da, db;
    e  = '0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      0: begin
        r = a + b + c;
        e.add = 8'(r); e.acr = (r > 255);
        sr = sa + sb + c; e.avr = (sr > 127 || sr < -128);
        e.hc = ((a % 16) + (b % 16) + c) >= 16;
      end
      1: begin
        r = a + (255 - b) + c;
        e.add = 8'(r); e.acr = (r > 255);
        sr = sa - sb - (1 - c); e.avr = (sr > 127 || sr < -128);
        e.hc = ((a % 16) + (15 - b % 16) + c) >= 16;
      end
      2: e.add = 8'(a & b);
      3: e.add = 8'(a | b);
      4: e.add = 8'(a ^ b);
      5: begin e.add = 8'((c << 7) | (a >> 1)); e.acr = a[0]; end
      6: begin e.add = 8'((a << 1) | c); e.acr = a[7]; end
      default: e.add = 8'(a);
    endcase
    if (BCD_EN && dec != 0 && op < 2) begin
      da = (a / 16) * 10 + (a % 16);
      db = (b / 16) * 10 + (b % 16);
      if (op == 0) begin
        r = da + db + c;
        e.acr = (r >= 100);
        r = r % 100;
        e.hc = ((a % 16) + (b % 16) + c) >= 10;
      end else begin
        r = da - db - (1 - c);
        e.acr = (r >= 0);
        if (r < 0) r = r + 100;
        e.hc = ((a % 16) - (b % 16) - (1 - c)) >= 0;
      end
      e.add = 8'((r / 10) * 16 + (r % 10));
    end
    e.zero = (e.add == 8'h00);
    e.neg  = e.add[7];
    return e;
  endfunction

  task automatic applyStimulus(input int op, input int a, input int b, input int c, input int dec);
    int n = 0;
    while (!o_ready && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (!o_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    i_op    = 3'(op);
    i_ai    = 8'(a);
    i_bi    = 8'(b);
    i_carry = c[0];
    i_dec   = dec[0];
    i_valid = 1'b1;
    q.push_back(model(op, a, b, c, dec));
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic checkOutput(input exp_t e);
    check("add",  o_add,  e.add);
    check("acr",  o_acr,  e.acr);
    check("avr",  o_avr,  e.avr);
    check("hc",   o_hc,   e.hc);
    check("zero", o_zero, e.zero);
    check("neg",  o_neg,  e.neg);
  endtask

  // Monitor: every completion pops the oldest expectation.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid) begin
      if (q.size() == 0) check("unexpected_valid", 1, 0);
      else checkOutput(q.pop_front());
    end
  end

  task automatic checkResetState(input string tag);
    check({tag, "_add"},   o_add,   0);
    check({tag, "_flags"}, {o_acr, o_avr, o_hc, o_zero, o_neg}, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_ready"}, o_ready, 1);
  endtask

  initial begin
    int op, a, b, c, dec, n;
    i_rst = 1'b1; i_valid = 1'b0; i_op = '0; i_ai = '0; i_bi = '0;
    i_carry = 1'b0; i_dec = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checkResetState("reset");
    i_rst = 1'b0;

    // Binary SUM with signed overflow, latency 1
    applyStimulus(0, 8'h50, 8'h50, 0, 0);
    check("bin_latency_valid", o_valid, 1);
    check("bin_ready", o_ready, 1);

    // SUB then back-to-back AND
    applyStimulus(1, 8'h00, 8'h01, 1, 0);
    applyStimulus(2, 8'hF0, 8'h3C, 0, 0);
    check("b2b_valid", o_valid, 1);
    check("b2b_and", o_add, 8'h30);

    // Decimal SUM
    applyStimulus(0, 8'h58, 8'h46, 1, 1);
    if (BCD_EN) begin
      check("dec_ready_e0", o_ready, 0);
      @(posedge i_clk); #1;
      check("dec_ready_e1", o_ready, 0);
      @(posedge i_clk); #1;
      check("dec_ready_e2", o_ready, 1);
      check("dec_latency_valid", o_valid, 1);
    end

    // Decimal SUB with an ignored request during DEC
    applyStimulus(1, 8'h12, 8'h21, 1, 1);
    if (BCD_EN) begin
      i_op = 3'd2; i_ai = 8'hFF; i_bi = 8'hFF; i_valid = 1'b1;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      check("dec_sub_valid", o_valid, 1);
    end

    // Shifts and pass
    applyStimulus(5, 8'h81, 8'h00, 1, 0);
    applyStimulus(6, 8'h81, 8'h00, 0, 0);
    applyStimulus(7, 8'h81, 8'h00, 0, 0);

    // Reset during a decimal op
    applyStimulus(0, 8'h99, 8'h99, 1, 1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    q.delete();
    checkResetState("midreset");
    i_rst = 1'b0;
    applyStimulus(7, 8'h3C, 8'h00, 0, 0);
    check("post_reset_accept", o_valid, 1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      op  = int'($urandom_range(0, 7));
      dec = int'($urandom_range(0, 1));
      c   = int'($urandom_range(0, 1));
      if (dec != 0 && op < 2) begin
        a = int'(($urandom_range(0, 9) << 4) | $urandom_range(0, 9));
        b = int'(($urandom_range(0, 9) << 4) | $urandom_range(0, 9));
      end else begin
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
      end
      applyStimulus(op, a, b, c, dec);
    end

    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
